// File: rtl/bit_serial_accumulator.sv
// Bit-sparse MAC stage: pops set-bit positions of each activation from the bit-converter FIFO
// and accumulates the weight shifted by each position, reporting the sum per activation.
module bit_serial_accumulator #(
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 20
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ActBitPlacesFIFOReadReady,
    output logic                ActBitPlacesFIFOReadEnable,
    input  logic [4:0]          ActBitPlacesFIFOReadDataOut,
    input  logic [WEIGHT_W-1:0] WeightIn,
    input  logic                WeightValid,
    output logic                WeightReady,
    input  logic                ClearAcc,
    output logic [ACC_W-1:0]    AccOut,
    output logic                AccValid,
    output logic                Busy
);

    typedef enum logic [1:0] {StIdle, StPop, StData} state_t;

    state_t              state;
    logic [WEIGHT_W-1:0] weight;
    logic [ACC_W-1:0]    partial;

    logic                entryLast;
    logic                entryZero;
    logic [2:0]          entryPlace;
    logic [ACC_W-1:0]    weightExt;
    logic [ACC_W-1:0]    term;
    logic [ACC_W-1:0]    accBase;

    always_comb begin
        entryLast  = ActBitPlacesFIFOReadDataOut[4];
        entryZero  = ActBitPlacesFIFOReadDataOut[3];
        entryPlace = ActBitPlacesFIFOReadDataOut[2:0];
        weightExt  = {{(ACC_W - WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
        term       = entryZero ? '0 : (weightExt << entryPlace);
        // Clear takes effect before a coincident completion adds its product
        accBase    = ClearAcc ? '0 : AccOut;
    end

    // Pop is combinational so back-to-back entries stream at one per cycle; never pops empty
    always_comb begin
        ActBitPlacesFIFOReadEnable = 1'b0;
        if (!RST && ActBitPlacesFIFOReadReady) begin
            ActBitPlacesFIFOReadEnable = (state == StPop) || ((state == StData) && !entryLast);
        end
        WeightReady = (state == StIdle);
        Busy        = (state != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= StIdle;
            weight   <= '0;
            partial  <= '0;
            AccOut   <= '0;
            AccValid <= 1'b0;
        end else begin
            AccValid <= 1'b0;
            if (ClearAcc) begin
                AccOut <= '0;
            end
            unique case (state)
                StIdle: begin
                    partial <= '0;
                    if (WeightValid) begin
                        weight <= WeightIn;
                        state  <= StPop;
                    end
                end
                StPop: begin
                    if (ActBitPlacesFIFOReadReady) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (entryLast) begin
                        AccOut   <= accBase + partial + term;
                        AccValid <= 1'b1;
                        state    <= StIdle;
                    end else begin
                        partial <= partial + term;
                        state   <= ActBitPlacesFIFOReadReady ? StData : StPop;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_accumulator.sv
// Directed bench for bit_serial_accumulator with a behavioural FIFO that returns data one
// cycle after each pop.
module tb_bit_serial_accumulator;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ReadReady;
    logic        ReadEnable;
    logic [4:0]  DataOut = '0;
    logic [7:0]  WeightIn;
    logic        WeightValid;
    logic        WeightReady;
    logic        ClearAcc;
    logic [19:0] AccOut;
    logic        AccValid;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    logic [4:0] mem [0:63];
    int wrPtr = 0;
    int rdPtr = 0;
    int popCount = 0;
    int validCount = 0;
    int badPops = 0;

    always #5 CLK = ~CLK;

    bit_serial_accumulator #(.WEIGHT_W(8), .ACC_W(20)) dut (
        .CLK                        (CLK),
        .RST                        (RST),
        .ActBitPlacesFIFOReadReady  (ReadReady),
        .ActBitPlacesFIFOReadEnable (ReadEnable),
        .ActBitPlacesFIFOReadDataOut(DataOut),
        .WeightIn                   (WeightIn),
        .WeightValid                (WeightValid),
        .WeightReady                (WeightReady),
        .ClearAcc                   (ClearAcc),
        .AccOut                     (AccOut),
        .AccValid                   (AccValid),
        .Busy                       (Busy)
    );

    assign ReadReady = (wrPtr != rdPtr);

    always @(posedge CLK) begin
        if (ReadEnable === 1'b1 && ReadReady) begin
            DataOut  <= mem[rdPtr[5:0]];
            rdPtr    <= rdPtr + 1;
            popCount <= popCount + 1;
        end
    end

    always @(negedge CLK) begin
        if (AccValid === 1'b1) validCount <= validCount + 1;
        if (ReadEnable === 1'b1 && !ReadReady) badPops <= badPops + 1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [4:0] e);
        mem[wrPtr[5:0]] = e;
        wrPtr++;
    endtask

    task automatic sendWeight(input string tag, input logic [7:0] w);
        WeightIn    = w;
        WeightValid = 1'b1;
        check({tag, " wready"}, longint'(WeightReady), 1);
        step();
        WeightValid = 1'b0;
    endtask

    task automatic waitValid(input int maxCyc, output int n);
        n = 0;
        while (AccValid !== 1'b1 && n < maxCyc) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int p0;
        int v0;
        RST = 1'b1; WeightIn = '0; WeightValid = 1'b0; ClearAcc = 1'b0;
        step(); step();
        check("rst accout", longint'($signed(AccOut)), 0);
        check("rst accvalid", longint'(AccValid), 0);
        check("rst readen", longint'(ReadEnable), 0);
        check("rst wready", longint'(WeightReady), 1);
        check("rst busy", longint'(Busy), 0);
        RST = 1'b0;
        step();

        // 1: weight 3, act 0x12 -> 3*2 + 3*16
        p0 = popCount; v0 = validCount;
        push(5'b00001); push(5'b10100);
        sendWeight("t1", 8'sd3);
        check("t1 busy", longint'(Busy), 1);
        waitValid(20, n);
        check("t1 latency", n, 3);
        check("t1 accout", longint'($signed(AccOut)), 54);
        check("t1 pops", popCount - p0, 2);
        step();
        check("t1 pulse", longint'(AccValid), 0);
        check("t1 vcount", validCount - v0, 1);
        check("t1 idle wready", longint'(WeightReady), 1);

        // 2: weight -2, act 0x12 -> 54 - 36; then zero activation
        push(5'b00001); push(5'b10100);
        sendWeight("t2a", 8'hFE);
        waitValid(20, n);
        check("t2a accout", longint'($signed(AccOut)), 18);
        step();
        p0 = popCount;
        push(5'b11000);
        sendWeight("t2b", 8'sd5);
        waitValid(20, n);
        check("t2b latency", n, 2);
        check("t2b accvalid", longint'(AccValid), 1);
        check("t2b accout", longint'($signed(AccOut)), 18);
        check("t2b pops", popCount - p0, 1);
        step();

        // 3: weight -128, act 0xFF -> -128*255 from a cleared accumulator
        ClearAcc = 1'b1; step(); ClearAcc = 1'b0;
        check("t3 pre-clear", longint'($signed(AccOut)), 0);
        p0 = popCount;
        for (int i = 0; i < 7; i++) push({2'b00, 3'(i)});
        push(5'b10111);
        sendWeight("t3", 8'h80);
        waitValid(30, n);
        check("t3 latency", n, 9);
        check("t3 accout", longint'($signed(AccOut)), -32640);
        check("t3 pops", popCount - p0, 8);
        step();
        ClearAcc = 1'b1; step(); ClearAcc = 1'b0;
        check("t3 clear", longint'($signed(AccOut)), 0);

        // 4: FIFO empty between places 1 and 4
        v0 = validCount;
        push(5'b00001);
        sendWeight("t4", 8'sd3);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t4 stall readen", longint'(ReadEnable), 0);
            check("t4 stall accout", longint'($signed(AccOut)), 0);
            check("t4 stall wready", longint'(WeightReady), 0);
            step();
        end
        check("t4 stall vcount", validCount - v0, 0);
        push(5'b10100);
        waitValid(20, n);
        check("t4 accout", longint'($signed(AccOut)), 54);
        step();

        // 5: clear coincident with completion; preload 100 = weight 1, act 0x64
        ClearAcc = 1'b1; step(); ClearAcc = 1'b0;
        push(5'b00010); push(5'b00101); push(5'b10110);
        sendWeight("t5a", 8'sd1);
        waitValid(20, n);
        check("t5 preload", longint'($signed(AccOut)), 100);
        step();
        push(5'b00001); push(5'b10100);
        sendWeight("t5", 8'sd3);
        step(); step();
        ClearAcc = 1'b1;
        step();
        ClearAcc = 1'b0;
        check("t5 accvalid", longint'(AccValid), 1);
        check("t5 accout", longint'($signed(AccOut)), 54);
        step();

        // 6: reset while in DATA of act 0x12
        p0 = popCount;
        push(5'b00001); push(5'b10100);
        sendWeight("t6", 8'sd3);
        step();
        RST = 1'b1;
        step();
        check("t6 accout", longint'($signed(AccOut)), 0);
        check("t6 accvalid", longint'(AccValid), 0);
        check("t6 readen", longint'(ReadEnable), 0);
        check("t6 wready", longint'(WeightReady), 1);
        RST = 1'b0;
        check("t6 pops", popCount - p0, 1);
        check("never pop empty", badPops, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
